// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage issue/collect controller for the multi-cycle RISC-V divider.
// Latches operands, runs the start/ready handshake, and resolves trivial cases locally.
module div_ctrl #(
    parameter int BYPASS_EN = 1
) (
    input  logic        ck_i,
    input  logic        rs_n_i,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_drain_last;
    logic        r_rem_sel;
    logic        r_signed;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [31:0] r_wb_data;
    logic [31:0] w_wb_data_next;
    logic [31:0] w_bypass_data;
    logic        w_accept;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_bypass;

    assign w_accept   = (r_state == S_IDLE) & req_i & ~flush_i;
    assign w_div_zero = (rs2_i == 32'd0);
    assign w_ovf      = ~op_i[0] & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
    assign w_bypass   = (BYPASS_EN != 0) & (w_div_zero | w_ovf);

    // Divide-by-zero takes precedence; REM of x/0 returns x, DIV returns all ones.
    assign w_bypass_data = w_div_zero ? (op_i[1] ? rs1_i : 32'hFFFF_FFFF)
                                      : (op_i[1] ? 32'd0 : 32'h8000_0000);

    always_comb begin
        w_next         = r_state;
        w_wb_data_next = r_wb_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bypass) begin
                        w_next         = S_DONE;
                        w_wb_data_next = w_bypass_data;
                    end else begin
                        w_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // A flush wins over a simultaneous ready: the result is discarded.
                if (flush_i) begin
                    w_next = S_DRAIN;
                end else if (div_ready_i) begin
                    w_next         = S_DONE;
                    w_wb_data_next = r_rem_sel ? div_result_i[63:32] : div_result_i[31:0];
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (r_drain_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (!rs_n_i) begin
            r_state      <= S_IDLE;
            r_drain_last <= 1'b0;
            r_rem_sel    <= 1'b0;
            r_signed     <= 1'b0;
            r_dividend   <= 32'd0;
            r_divisor    <= 32'd0;
            r_wb_data    <= 32'd0;
        end else begin
            r_state      <= w_next;
            r_drain_last <= (r_state == S_DRAIN) & ~r_drain_last;
            r_wb_data    <= w_wb_data_next;
            if (w_accept) begin
                r_rem_sel  <= op_i[1];
                r_signed   <= ~op_i[0];
                r_dividend <= rs1_i;
                r_divisor  <= rs2_i;
            end
        end
    end

    assign div_start_o    = (r_state == S_BUSY);
    assign div_annul_o    = (r_state == S_DRAIN);
    assign div_signed_o   = r_signed;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;
    assign wb_data_o      = r_wb_data;
    assign wb_valid_o     = (r_state == S_DONE) & ~flush_i;
    // Gate with reset so a held request cannot raise stall while the block is held in reset.
    assign stall_o        = rs_n_i & (w_accept | (r_state == S_BUSY));

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: two div_ctrl instances (bypass on / off) driven by directed and random
// div/rem instructions, each checked every cycle against a transaction-level model.
module tb_div_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       req, flush;
    logic [1:0][1:0]  op;
    logic [1:0][31:0] rs1, rs2;
    logic [1:0]       stall, wbv, start, annul, sgn;
    logic [1:0][31:0] wbd, dvd, dvs;
    logic [1:0]       dready;
    logic [1:0][63:0] dres;

    div_ctrl #(.BYPASS_EN(1)) u_dut0 (
        .ck_i(clk), .rs_n_i(rst_n), .req_i(req[0]), .op_i(op[0]), .rs1_i(rs1[0]), .rs2_i(rs2[0]),
        .flush_i(flush[0]), .stall_o(stall[0]), .wb_valid_o(wbv[0]), .wb_data_o(wbd[0]),
        .div_start_o(start[0]), .div_annul_o(annul[0]), .div_signed_o(sgn[0]),
        .div_dividend_o(dvd[0]), .div_divisor_o(dvs[0]), .div_ready_i(dready[0]),
        .div_result_i(dres[0]));

    div_ctrl #(.BYPASS_EN(0)) u_dut1 (
        .ck_i(clk), .rs_n_i(rst_n), .req_i(req[1]), .op_i(op[1]), .rs1_i(rs1[1]), .rs2_i(rs2[1]),
        .flush_i(flush[1]), .stall_o(stall[1]), .wb_valid_o(wbv[1]), .wb_data_o(wbd[1]),
        .div_start_o(start[1]), .div_annul_o(annul[1]), .div_signed_o(sgn[1]),
        .div_dividend_o(dvd[1]), .div_divisor_o(dvs[1]), .div_ready_i(dready[1]),
        .div_result_i(dres[1]));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // RISC-V M-extension result for op (00 DIV, 01 DIVU, 10 REM, 11 REMU).
    function automatic logic [31:0] rv_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!o[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    // Divider model: ready after lat cycles of start, held until start drops.
    int lat [2];
    int dcnt [2];
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                dcnt[i]   <= 0;
                dready[i] <= 1'b0;
                dres[i]   <= 64'd0;
            end else if (!start[i]) begin
                dcnt[i]   <= 0;
                dready[i] <= annul[i] && ($urandom_range(0, 1) == 1);
                dres[i]   <= {$urandom, $urandom};
            end else begin
                dcnt[i] <= dcnt[i] + 1;
                if (dcnt[i] + 1 >= lat[i]) begin
                    dready[i] <= 1'b1;
                    dres[i]   <= {rv_div({1'b1, ~sgn[i]}, dvd[i], dvs[i]),
                                  rv_div({1'b0, ~sgn[i]}, dvd[i], dvs[i])};
                end else begin
                    dready[i] <= 1'b0;
                    dres[i]   <= {$urandom, $urandom};
                end
            end
        end
    end

    // Transaction-level reference: what each instruction must look like on the outputs.
    bit          m_busy [2];
    bit          m_ret  [2];
    int          m_drain[2];
    bit          m_sgn  [2];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic [31:0] m_data [2];

    always @(negedge clk) begin
        bit idle, e_stall, e_wbv, special;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0; m_ret[i] = 0; m_drain[i] = 0; m_sgn[i] = 0;
                m_a[i] = 0; m_b[i] = 0; m_data[i] = 0;
                chk("rst_stall", i, 64'(stall[i]), 64'd0);
                chk("rst_wbv", i, 64'(wbv[i]), 64'd0);
                chk("rst_start", i, 64'(start[i]), 64'd0);
                chk("rst_annul", i, 64'(annul[i]), 64'd0);
                chk("rst_ops", i, {31'd0, sgn[i], dvd[i] | dvs[i] | wbd[i]}, 64'd0);
            end else begin
                idle    = !m_busy[i] && !m_ret[i] && m_drain[i] == 0;
                e_stall = (idle && req[i] && !flush[i]) || m_busy[i];
                e_wbv   = m_ret[i] && !flush[i];
                chk("stall", i, 64'(stall[i]), 64'(e_stall));
                chk("start", i, 64'(start[i]), 64'(m_busy[i]));
                chk("annul", i, 64'(annul[i]), 64'(m_drain[i] > 0));
                chk("wb_valid", i, 64'(wbv[i]), 64'(e_wbv));
                chk("signed", i, 64'(sgn[i]), 64'(m_sgn[i]));
                chk("operands", i, {dvd[i], dvs[i]}, {m_a[i], m_b[i]});
                if (e_wbv) chk("wb_data", i, 64'(wbd[i]), 64'(m_data[i]));

                if (m_ret[i]) begin
                    m_ret[i] = 0;
                end else if (m_drain[i] > 0) begin
                    m_drain[i]--;
                end else if (m_busy[i]) begin
                    if (flush[i]) begin
                        m_busy[i]  = 0;
                        m_drain[i] = 2;
                    end else if (dready[i]) begin
                        m_busy[i] = 0;
                        m_ret[i]  = 1;
                    end
                end else if (req[i] && !flush[i]) begin
                    m_sgn[i]  = ~op[i][0];
                    m_a[i]    = rs1[i];
                    m_b[i]    = rs2[i];
                    m_data[i] = rv_div(op[i], rs1[i], rs2[i]);
                    special   = (rs2[i] == 0) ||
                                (!op[i][0] && rs1[i] == 32'h8000_0000 && rs2[i] == 32'hFFFF_FFFF);
                    if (i == 0 && special) m_ret[i] = 1;
                    else                   m_busy[i] = 1;
                end
            end
        end
    end

    // Activity counters for the directed literal checks.
    int          c_stall[2], c_start[2], c_annul[2], c_wbv[2];
    logic [31:0] last_wbd[2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            c_stall[i] += int'(stall[i]);
            c_start[i] += int'(start[i]);
            c_annul[i] += int'(annul[i]);
            c_wbv[i]   += int'(wbv[i]);
            if (wbv[i]) last_wbd[i] = wbd[i];
        end
    end

    int b_stall, b_start, b_annul, b_wbv;
    task automatic snap(input int i);
        b_stall = c_stall[i]; b_start = c_start[i]; b_annul = c_annul[i]; b_wbv = c_wbv[i];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction to EX until it retires or is flushed (flush at cycle fl, -1 = none).
    task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int fl);
        int cyc;
        bit fin;
        req[i] = 1'b1; op[i] = o; rs1[i] = a; rs2[i] = b;
        cyc = 0;
        fin = 0;
        while (!fin && cyc < 300) begin
            flush[i] = (cyc == fl);
            @(negedge clk);
            if (wbv[i] || flush[i]) fin = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        req[i] = 1'b0;
        flush[i] = 1'b0;
        chk("op_retired", i, 64'(fin), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int i, fl;
        rst_n = 1'b0;
        req = '0; flush = '0; op = '0; rs1 = '0; rs2 = '0;
        lat[0] = 34; lat[1] = 34;
        step(3);
        rst_n = 1'b1;
        step(2);

        // DIVU 100/7 through the divider, 34-cycle latency
        snap(0);
        run_op(0, 2'b01, 32'd100, 32'd7, -1);
        step(3);
        chk("divu_stall_cycles", 0, 64'(c_stall[0] - b_stall), 64'd36);
        chk("divu_start_cycles", 0, 64'(c_start[0] - b_start), 64'd35);
        chk("divu_wbv_count", 0, 64'(c_wbv[0] - b_wbv), 64'd1);
        chk("divu_100_7", 0, 64'(last_wbd[0]), 64'd14);

        // REM -7 % 2
        lat[0] = 5;
        run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
        chk("rem_m7_2", 0, 64'(last_wbd[0]), 64'hFFFF_FFFF);

        // Divide by zero, bypassed locally
        snap(0);
        run_op(0, 2'b00, 32'd5, 32'd0, -1);
        chk("div_5_0", 0, 64'(last_wbd[0]), 64'hFFFF_FFFF);
        run_op(0, 2'b11, 32'd5, 32'd0, -1);
        chk("remu_5_0", 0, 64'(last_wbd[0]), 64'd5);
        step(1);
        chk("byp_zero_no_start", 0, 64'(c_start[0] - b_start), 64'd0);
        chk("byp_zero_wbv", 0, 64'(c_wbv[0] - b_wbv), 64'd2);
        chk("byp_zero_stall", 0, 64'(c_stall[0] - b_stall), 64'd2);

        // Same divide by zero with the bypass disabled goes to the divider
        lat[1] = 4;
        snap(1);
        run_op(1, 2'b00, 32'd5, 32'd0, -1);
        chk("nobyp_div_5_0", 1, 64'(last_wbd[1]), 64'hFFFF_FFFF);
        chk("nobyp_start_cycles", 1, 64'(c_start[1] - b_start), 64'd5);

        // Signed overflow, bypassed
        snap(0);
        run_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("div_ovf", 0, 64'(last_wbd[0]), 64'h8000_0000);
        run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("rem_ovf", 0, 64'(last_wbd[0]), 64'd0);
        chk("ovf_no_start", 0, 64'(c_start[0] - b_start), 64'd0);

        // Flush during BUSY, then a normal DIVU
        lat[0] = 34;
        snap(0);
        run_op(0, 2'b00, 32'd1000, 32'd3, 10);
        step(4);
        chk("flush_start_cycles", 0, 64'(c_start[0] - b_start), 64'd10);
        chk("flush_annul_cycles", 0, 64'(c_annul[0] - b_annul), 64'd2);
        chk("flush_no_wbv", 0, 64'(c_wbv[0] - b_wbv), 64'd0);
        lat[0] = 6;
        snap(0);
        run_op(0, 2'b01, 32'd9, 32'd3, -1);
        step(2);
        chk("after_flush_wbv", 0, 64'(c_wbv[0] - b_wbv), 64'd1);
        chk("divu_9_3", 0, 64'(last_wbd[0]), 64'd3);

        // Asynchronous reset mid-BUSY
        lat[0] = 34;
        req[0] = 1'b1; op[0] = 2'b01; rs1[0] = 32'd77; rs2[0] = 32'd5;
        step(6);
        rst_n = 1'b0;
        #1;
        chk("async_rst_start", 0, 64'(start[0]), 64'd0);
        chk("async_rst_stall", 0, 64'(stall[0]), 64'd0);
        chk("async_rst_wb", 0, {31'd0, wbv[0], wbd[0]}, 64'd0);
        chk("async_rst_ops", 0, {annul[0], sgn[0], dvd[0] | dvs[0]}, 64'd0);
        req[0] = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        run_op(0, 2'b01, 32'd8, 32'd2, -1);
        chk("divu_8_2", 0, 64'(last_wbd[0]), 64'd4);

        // Randomized instruction stream on both instances
        for (int n = 0; n < 80; n++) begin
            i = $urandom_range(0, 1);
            lat[i] = $urandom_range(1, 12);
            fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : -1;
            run_op(i, 2'($urandom_range(0, 3)), pick(), pick(), fl);
            if ($urandom_range(0, 1) == 1) step($urandom_range(1, 3));
        end

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
